// File: rtl/seg7_mux2.sv
// Two-digit multiplexed 7-segment driver: latches BCD digits once per frame and
// time-multiplexes them onto a shared segment bus with blank gaps between digits.
module seg7_mux2 #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter bit          LZ_BLANK     = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_ones,
  input  logic [3:0] i_tens,
  output logic [6:0] o_seg,
  output logic [1:0] o_an,
  output logic       o_frame
);

  localparam int unsigned MAX_DWELL = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W     = (MAX_DWELL > 1) ? $clog2(MAX_DWELL) : 1;
  localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [6:0] SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic [1:0] AN_OFF  = {2{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    S_DIG0 = 2'd0,
    S_BLK0 = 2'd1,
    S_DIG1 = 2'd2,
    S_BLK1 = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       ones_q, ones_d;
  logic [3:0]       tens_q, tens_d;
  logic [6:0]       seg_d;
  logic [1:0]       an_d;
  logic             frame_d;
  logic             dwell_done;
  logic [6:0]       seg_lit;
  logic [1:0]       an_lit;

  // BCD to segments, bit6=g .. bit0=a; non-BCD codes show 'E'
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b1111001;
    endcase
    return s;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_BLK1;
      cnt_q   <= '0;
      ones_q  <= '0;
      tens_q  <= '0;
      o_seg   <= SEG_OFF;
      o_an    <= AN_OFF;
      o_frame <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      o_seg   <= seg_d;
      o_an    <= an_d;
      o_frame <= frame_d;
    end
  end

  // Next state plus registered outputs computed from the state being entered
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    ones_d     = ones_q;
    tens_d     = tens_q;
    frame_d    = 1'b0;
    seg_lit    = 7'b0;
    an_lit     = 2'b00;
    dwell_done = 1'b0;

    unique case (state_q)
      S_DIG0, S_DIG1: dwell_done = (cnt_q == DIG_LAST);
      default:        dwell_done = (cnt_q == BLK_LAST);
    endcase

    if (dwell_done) begin
      cnt_d = '0;
      unique case (state_q)
        S_DIG0:  state_d = S_BLK0;
        S_BLK0:  state_d = S_DIG1;
        S_DIG1:  state_d = S_BLK1;
        default: state_d = S_DIG0;
      endcase
    end

    // Digits are sampled only at frame start so a frame never tears
    if (state_q == S_BLK1 && state_d == S_DIG0) begin
      ones_d  = i_ones;
      tens_d  = i_tens;
      frame_d = 1'b1;
    end

    unique case (state_d)
      S_DIG0: begin
        an_lit  = 2'b01;
        seg_lit = decode(ones_d);
      end
      S_DIG1: begin
        if (!(LZ_BLANK && tens_d == 4'd0)) begin
          an_lit  = 2'b10;
          seg_lit = decode(tens_d);
        end
      end
      default: begin
        an_lit  = 2'b00;
        seg_lit = 7'b0;
      end
    endcase

    seg_d = ACTIVE_LOW ? ~seg_lit : seg_lit;
    an_d  = ACTIVE_LOW ? ~an_lit : an_lit;
  end

endmodule
